tdc_fine_measure: RTL and testbench
===================================

// Module: tdc_fine_measure
// PURPOSE
//  Next-generation fine stage for the carry-chain TDC. Takes the first-FF column
//  sample of a NUM_TAPS delay line and runs the start/stop sequencing on chip.
//  Detects start and stop hits, encodes each thermometer sample to a tap count,
//  and counts whole clk cycles between the two hits. Sits between the CARRY4
//  chain/first FF column and the time-interval calculator.
//  Replaces the externally driven start/stop enable columns.
// PARAMETERS
//  NUM_TAPS    48  delay-line taps; multiple of 4
//  COARSE_W    16  coarse cycle counter width
//  AUTO_REARM  0   1: return to ARMED after a handshake; 0: return to IDLE
//  TAP_W       localparam = $clog2(NUM_TAPS+1), fine result width
// PORTS
//  clk          in   1         sampling clock, same clock as the first FF column
//  iRst_n       in   1         asynchronous, active-low reset
//  iTaps        in   NUM_TAPS  first-FF sample; bit0 = earliest tap
//  iArm         in   1         1-cycle request to arm a measurement
//  iReady       in   1         consumer accepts the result
//  oBusy        out  1         high in any state except IDLE
//  oValid       out  1         result available
//  oFineStart   out  TAP_W     popcount of iTaps at the start capture edge
//  oFineStop    out  TAP_W     popcount of iTaps at the stop capture edge
//  oCoarse      out  COARSE_W  clk edges from the start capture to the stop capture
//  oTimeout     out  1         1-cycle pulse: measurement aborted, no stop seen
// BEHAVIOUR
//  - Reset (asynchronous, any state): state IDLE, every output 0, counter 0, tap0_q 0.
//  - tap0_q <= iTaps[0] on every edge. rise = iTaps[0] & ~tap0_q.
//  - Encoding: fine = popcount(iTaps), sampled on the capture edge. Popcount is
//    bubble-tolerant. An all-ones line gives NUM_TAPS.
//  - FSM states IDLE, ARMED, RUN, DONE:
//    IDLE : iArm -> ARMED. A rise in the same cycle as iArm is ignored.
//    ARMED: rise -> RUN. Latch oFineStart and clear the counter to 0.
//    RUN  : counter increments on every edge. A rise at counter value c-1 moves
//           to DONE and latches oFineStop and oCoarse = c. The minimum legal c is 2,
//           because tap0 must drop before the next rise.
//           If the counter is 2^COARSE_W-1 and there is no rise: assert oTimeout
//           for 1 cycle, go to IDLE, do not assert oValid.
//    DONE : oValid = 1. oFineStart, oFineStop and oCoarse hold stable while
//           oValid & ~iReady. oValid & iReady -> IDLE (AUTO_REARM=0) or
//           ARMED (AUTO_REARM=1). oValid drops on the same edge.
//  - Latency: oValid and the stop results update on the same edge that samples
//    the stop rise.
//  - In DONE: hits are ignored. iArm is ignored in every state except IDLE.
//  - The chain is not cleared between hits. A hit wider than one clk gives a
//    single rise only.
// CONFIGURATION
//  TDC_ENC_PIPE_EN defined:
//   - iTaps is registered one extra stage before popcount and rise detection.
//   - Every event and output moves one edge later. oCoarse values are unchanged.
//   - Use when NUM_TAPS > 128 for timing closure.
//  TDC_ENC_PIPE_EN undefined:
//   - Combinational popcount feeds the capture registers, with the latency above.
// TESTING
//  1. NUM_TAPS=48. Pulse iArm. iTaps: 0, then 48'h00F at edge 10, 0 on edges
//     11-12, 48'hFFFFF at edge 15 -> oValid at edge 15, oFineStart=4,
//     oFineStop=20, oCoarse=5.
//  2. Same as 1 with iReady low for 3 cycles and a hit applied during DONE ->
//     outputs held, the hit is ignored, oValid drops on the iReady edge, oBusy=0.
//  3. COARSE_W=4. Start at edge k, no stop -> oTimeout pulse at edge k+16, then
//     IDLE, oValid never set.
//  4. Stop sample with a bubble, iTaps=8'b1011_1111 (upper bits 0) -> oFineStop=7.
//  5. iRst_n low in RUN, asynchronous mid-cycle -> all outputs 0 immediately.
//     A new arm plus two hits gives a correct result.
//  6. Scenario 1 with TDC_ENC_PIPE_EN and AUTO_REARM=1 -> oValid at edge 16,
//     same values. After the handshake oBusy=1 and the FSM is in ARMED.

Source files
------------

// File: rtl/tdc_fine_measure_if.sv
// Purpose : bundles the tap sample, arm/accept controls and the measurement results
//           of the TDC fine stage into one port.
// Ports   : iTaps/iArm/iReady flow toward the fine stage; oBusy/oValid/oFineStart/
//           oFineStop/oCoarse/oTimeout flow back. Master = driver, slave = fine stage.
interface tdc_fine_measure_if #(
  parameter int NUM_TAPS = 48,
  parameter int COARSE_W = 16
);
  localparam int TAP_W = $clog2(NUM_TAPS + 1);

  logic [NUM_TAPS-1:0] iTaps;
  logic                iArm;
  logic                iReady;
  logic                oBusy;
  logic                oValid;
  logic [TAP_W-1:0]    oFineStart;
  logic [TAP_W-1:0]    oFineStop;
  logic [COARSE_W-1:0] oCoarse;
  logic                oTimeout;

  modport master (
    output iTaps, iArm, iReady,
    input  oBusy, oValid, oFineStart, oFineStop, oCoarse, oTimeout
  );

  modport slave (
    input  iTaps, iArm, iReady,
    output oBusy, oValid, oFineStart, oFineStop, oCoarse, oTimeout
  );
endinterface

// File: rtl/tdc_fine_measure.sv
// Purpose     : carry-chain TDC fine stage; detects start/stop hits on tap0, popcounts the
//               thermometer sample at each hit and counts whole clk cycles between them.
// Latency     : results and oValid update on the edge that samples the stop rise
//               (one edge later with TDC_ENC_PIPE_EN defined, which registers iTaps first).
// Backpressure: DONE holds the results until iReady; hits are ignored meanwhile.
// Ports       : clk, iRst_n (async, active low), bus (tdc_fine_measure_if.slave).
module tdc_fine_measure #(
  parameter int NUM_TAPS   = 48,
  parameter int COARSE_W   = 16,
  parameter bit AUTO_REARM = 1'b0
) (
  input  logic              clk,
  input  logic              iRst_n,
  tdc_fine_measure_if.slave bus
);

  localparam int TAP_W = $clog2(NUM_TAPS + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARMED = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [COARSE_W-1:0] CNT_MAX = '1;

  logic [1:0]          state;
  logic [COARSE_W-1:0] counter;
  logic                tap0Q;
  logic [TAP_W-1:0]    fineStartQ;
  logic [TAP_W-1:0]    fineStopQ;
  logic [COARSE_W-1:0] coarseQ;
  logic                timeoutQ;
  logic [NUM_TAPS-1:0] tapsEnc;
  logic [TAP_W-1:0]    fineNow;
  logic                rise;

`ifdef TDC_ENC_PIPE_EN
  // Extra register stage ahead of the adder tree for wide delay lines.
  logic [NUM_TAPS-1:0] tapsQ;

  always_ff @(posedge clk or negedge iRst_n) begin
    if (!iRst_n) begin
      tapsQ <= '0;
    end else begin
      tapsQ <= bus.iTaps;
    end
  end

  assign tapsEnc = tapsQ;
`else
  assign tapsEnc = bus.iTaps;
`endif

  // Counting ones rather than finding the first zero makes the code immune
  // to bubbles in the thermometer sample.
  function automatic logic [TAP_W-1:0] popcount(input logic [NUM_TAPS-1:0] v);
    logic [TAP_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUM_TAPS; i++) begin
      cnt = cnt + TAP_W'(v[i]);
    end
    return cnt;
  endfunction

  assign fineNow = popcount(tapsEnc);

  // A hit lasting several cycles keeps tap0 high; only its leading edge counts.
  assign rise = tapsEnc[0] & ~tap0Q;

  always_ff @(posedge clk or negedge iRst_n) begin
    if (!iRst_n) begin
      state      <= IDLE;
      counter    <= '0;
      tap0Q      <= 1'b0;
      fineStartQ <= '0;
      fineStopQ  <= '0;
      coarseQ    <= '0;
      timeoutQ   <= 1'b0;
    end else begin
      tap0Q    <= tapsEnc[0];
      timeoutQ <= 1'b0;
      case (state)
        IDLE: begin
          // A rise coinciding with the arm request is deliberately not a start.
          if (bus.iArm) begin
            state <= ARMED;
          end
        end
        ARMED: begin
          if (rise) begin
            state      <= RUN;
            fineStartQ <= fineNow;
            counter    <= '0;
          end
        end
        RUN: begin
          counter <= counter + COARSE_W'(1);
          if (rise) begin
            // The counter trails the edge count by one: it reads c-1 on the
            // c-th edge after the start capture. A stop at terminal count
            // wraps oCoarse to 0.
            state     <= DONE;
            fineStopQ <= fineNow;
            coarseQ   <= counter + COARSE_W'(1);
          end else if (counter == CNT_MAX) begin
            state    <= IDLE;
            timeoutQ <= 1'b1;
          end
        end
        DONE: begin
          if (bus.iReady) begin
            state <= AUTO_REARM ? ARMED : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.oBusy      = (state != IDLE);
  assign bus.oValid     = (state == DONE);
  assign bus.oFineStart = fineStartQ;
  assign bus.oFineStop  = fineStopQ;
  assign bus.oCoarse    = coarseQ;
  assign bus.oTimeout   = timeoutQ;

endmodule

// File: tb/tb_tdc_fine_measure.sv
// Purpose : directed bench for tdc_fine_measure: 48-tap instances with AUTO_REARM
//           0 and 1 sharing one stimulus, plus an 8-tap COARSE_W=4 instance for timeout.
// Timing  : inputs change 1 time unit after a rising edge; outputs checked there too.
module tb_tdc_fine_measure;

`ifdef TDC_ENC_PIPE_EN
  localparam int PIPE = 1;
`else
  localparam int PIPE = 0;
`endif

  logic        clk = 1'b0;
  logic        rstN;
  logic [47:0] taps;
  logic        arm;
  logic        ready;
  logic [7:0]  tapsC;
  logic        armC;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tdc_fine_measure_if #(.NUM_TAPS(48), .COARSE_W(16)) busA ();
  tdc_fine_measure_if #(.NUM_TAPS(48), .COARSE_W(16)) busB ();
  tdc_fine_measure_if #(.NUM_TAPS(8),  .COARSE_W(4))  busC ();

  assign busA.iTaps  = taps;
  assign busA.iArm   = arm;
  assign busA.iReady = ready;
  assign busB.iTaps  = taps;
  assign busB.iArm   = arm;
  assign busB.iReady = ready;
  assign busC.iTaps  = tapsC;
  assign busC.iArm   = armC;
  assign busC.iReady = 1'b0;

  tdc_fine_measure #(.NUM_TAPS(48), .COARSE_W(16), .AUTO_REARM(1'b0)) dutA (
    .clk(clk), .iRst_n(rstN), .bus(busA));
  tdc_fine_measure #(.NUM_TAPS(48), .COARSE_W(16), .AUTO_REARM(1'b1)) dutB (
    .clk(clk), .iRst_n(rstN), .bus(busB));
  tdc_fine_measure #(.NUM_TAPS(8), .COARSE_W(4), .AUTO_REARM(1'b0)) dutC (
    .clk(clk), .iRst_n(rstN), .bus(busC));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chkResultA(input string tag, input int fs, input int fe, input int cc);
    chk({tag, " valid"}, 32'(busA.oValid), 1);
    chk({tag, " fineStart"}, 32'(busA.oFineStart), fs);
    chk({tag, " fineStop"}, 32'(busA.oFineStop), fe);
    chk({tag, " coarse"}, 32'(busA.oCoarse), cc);
  endtask

  task automatic handshakeA();
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("hs valid", 32'(busA.oValid), 0);
    chk("hs busy", 32'(busA.oBusy), 0);
  endtask

  initial begin
    rstN  = 1'b0;
    taps  = '0;
    arm   = 1'b0;
    ready = 1'b0;
    tapsC = '0;
    armC  = 1'b0;
    #23;
    chk("rst busy", 32'(busA.oBusy), 0);
    chk("rst valid", 32'(busA.oValid), 0);
    chk("rst coarse", 32'(busA.oCoarse), 0);
    chk("rst timeout", 32'(busC.oTimeout), 0);
    rstN = 1'b1;
    tick();

    // Scenario 1 (+ rearm/pipeline variant on instance B): arm at edge 1,
    // start hit at edge 10, stop hit at edge 15.
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("armed busyA", 32'(busA.oBusy), 1);
    chk("armed busyB", 32'(busB.oBusy), 1);
    for (int e = 2; e <= 16; e++) begin
      taps = (e == 10) ? 48'h00F : (e >= 15) ? 48'hFFFFF : 48'h0;
      tick();
      chk($sformatf("s1 validA e%0d", e), 32'(busA.oValid), (e >= 15 + PIPE) ? 1 : 0);
      chk($sformatf("s1 validB e%0d", e), 32'(busB.oValid), (e >= 15 + PIPE) ? 1 : 0);
      if (e == 10 + PIPE) begin
        chk("s1 run busy", 32'(busA.oBusy), 1);
      end
      if (e == 15 + PIPE) begin
        chkResultA("s1", 4, 20, 5);
        chk("s1 B fineStart", 32'(busB.oFineStart), 4);
        chk("s1 B fineStop", 32'(busB.oFineStop), 20);
        chk("s1 B coarse", 32'(busB.oCoarse), 5);
      end
    end

    // Scenario 2: consumer stalls three cycles while a new hit arrives.
    for (int e = 17; e <= 19; e++) begin
      taps = (e == 17) ? 48'h0 : 48'h0FF;
      tick();
      chkResultA($sformatf("s2 hold e%0d", e), 4, 20, 5);
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("s2 validA", 32'(busA.oValid), 0);
    chk("s2 busyA", 32'(busA.oBusy), 0);
    chk("s2 validB", 32'(busB.oValid), 0);
    chk("s2 rearm busyB", 32'(busB.oBusy), 1);

    // Scenario 4: stop sample with a bubble, 8'b1011_1111 -> 7 ones.
    arm  = 1'b1;
    taps = 48'h0;
    tick();
    arm  = 1'b0;
    taps = 48'h001;
    tick();
    taps = 48'h0;
    tick();
    tick();
    taps = 48'h0BF;
    tick();
    tick();
    chkResultA("s4", 1, 7, 3);
    handshakeA();

    // Scenario 5: asynchronous reset in the middle of a RUN cycle.
    arm  = 1'b1;
    taps = 48'h0;
    tick();
    arm  = 1'b0;
    taps = 48'h007;
    tick();
    taps = 48'h0;
    tick();
    tick();
    chk("s5 run busy", 32'(busA.oBusy), 1);
    chk("s5 run fineStart", 32'(busA.oFineStart), 3);
    #2;
    rstN = 1'b0;
    #1;
    chk("s5 rst busy", 32'(busA.oBusy), 0);
    chk("s5 rst valid", 32'(busA.oValid), 0);
    chk("s5 rst fineStart", 32'(busA.oFineStart), 0);
    chk("s5 rst fineStop", 32'(busA.oFineStop), 0);
    chk("s5 rst coarse", 32'(busA.oCoarse), 0);
    chk("s5 rst timeout", 32'(busA.oTimeout), 0);
    chk("s5 rst busyB", 32'(busB.oBusy), 0);
    #2;
    rstN = 1'b1;
    arm  = 1'b1;
    tick();
    arm  = 1'b0;
    taps = 48'h007;
    tick();
    taps = 48'h0;
    tick();
    tick();
    tick();
    taps = 48'h3FF;
    tick();
    tick();
    chkResultA("s5 after", 3, 10, 4);
    handshakeA();

    // Scenario 3: COARSE_W=4, start with no stop; the hit stays high.
    armC = 1'b1;
    tick();
    armC  = 1'b0;
    tapsC = 8'h01;
    tick();
    for (int m = 1; m <= 18; m++) begin
      tick();
      chk($sformatf("s3 timeout k+%0d", m), 32'(busC.oTimeout), (m == 16 + PIPE) ? 1 : 0);
      chk($sformatf("s3 valid k+%0d", m), 32'(busC.oValid), 0);
    end
    chk("s3 idle busy", 32'(busC.oBusy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
